sd_resp_receiver: RTL and testbench

- Receive side of the SD CMD line: the inverse of the command-side CRC7 generator.
- Arms on request, waits for the card's start bit, then deserialises a fixed-length response MSB-first.
- Computes CRC over the frame body, compares it with the received CRC field and checks the end bit.
- Presents the frame and status to the command controller until it releases the request.

---
 rtl/sd_pkg.sv | 8 +
 rtl/crc_serial_lfsr.sv | 19 +
 rtl/sd_resp_receiver.sv | 101 ++++++++++
 tb/tb_sd_resp_receiver.sv | 122 ++++++++++++
 4 files changed

// File: rtl/sd_pkg.sv
// sd_pkg: shared SD command-line constants and receiver state encoding
package sd_pkg;
  localparam logic [7:0] CRC7_POLY = 8'h89;
  localparam int NCR_TIMEOUT = 64;
  localparam int R1_LEN = 48;
  localparam int R2_LEN = 136;
  typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, DONE} rx_state_t;
endpackage

// File: rtl/crc_serial_lfsr.sv
// crc_serial_lfsr: one-bit-per-clock MSB-first CRC register, shared by tx and rx paths
module crc_serial_lfsr #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         enable,
  input  logic         din,
  input  logic [W-1:0] generator,
  output logic [W-1:0] crc
);
  logic fb;
  assign fb = crc[W-1] ^ din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) crc <= '0;
    else if (clear) crc <= '0;
    else if (enable) crc <= {crc[W-2:0], 1'b0} ^ (fb ? generator : '0);
endmodule

// File: rtl/sd_resp_receiver.sv
// sd_resp_receiver: arms on request, captures a fixed-length CMD-line response and checks CRC/end bit
module sd_resp_receiver
  import sd_pkg::*;
#(
  parameter int respLength    = R1_LEN,
  parameter int crcLength     = 7,
  parameter int timeoutCycles = NCR_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  useModule,
  input  logic                  cmd_in,
  input  logic [crcLength:0]    generator,
  input  logic                  skip_crc,
  output logic [respLength-1:0] resp_data,
  output logic                  busy,
  output logic                  finish,
  output logic                  crc_ok,
  output logic                  end_err,
  output logic                  timeout
);
  localparam int BW = $clog2(respLength + 1);
  localparam int WW = $clog2(timeoutCycles + 1);
  localparam logic [BW-1:0] CRC_END = BW'(crcLength + 1);
  rx_state_t state, state_nx;
  logic use_q, rise, fall, skip_q, crc_clear, crc_en, unused_gen_msb;
  logic [BW-1:0] bit_cnt;
  logic [WW-1:0] wait_cnt;
  logic [crcLength-1:0] crc;
  assign rise = useModule & ~use_q;
  assign fall = ~useModule & use_q;
  assign unused_gen_msb = generator[crcLength];
  assign crc_clear = (state == IDLE) & rise;
  // the CRC span ends before the CRC field, i.e. while bit_cnt is still above crcLength
  assign crc_en = ~fall & (((state == WAIT_START) & ~cmd_in) | ((state == RECEIVE) & (bit_cnt >= CRC_END)));
  crc_serial_lfsr #(.W(crcLength)) u_crc (
    .clk(clk), .rst_n(rst_n), .clear(crc_clear), .enable(crc_en), .din(cmd_in),
    .generator(generator[crcLength-1:0]), .crc(crc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       state_nx = rise ? WAIT_START : IDLE;
      WAIT_START: state_nx = fall ? IDLE : ~cmd_in ? RECEIVE :
                             (wait_cnt == WW'(timeoutCycles - 1)) ? DONE : WAIT_START;
      RECEIVE:    state_nx = fall ? IDLE : (bit_cnt == '0) ? DONE : RECEIVE;
      default:    state_nx = fall ? IDLE : DONE;
    endcase
  end
  always_comb busy = (state == WAIT_START) || (state == RECEIVE);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      use_q     <= 1'b0;
      skip_q    <= 1'b0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      resp_data <= '0;
      finish    <= 1'b0;
      crc_ok    <= 1'b0;
      end_err   <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      use_q <= useModule;
      case (state)
        IDLE: if (rise) begin
          finish    <= 1'b0;
          crc_ok    <= 1'b0;
          end_err   <= 1'b0;
          timeout   <= 1'b0;
          skip_q    <= skip_crc;
          wait_cnt  <= '0;
          resp_data <= '0;
        end
        WAIT_START: if (!fall) begin
          if (!cmd_in) begin
            resp_data <= {resp_data[respLength-2:0], cmd_in};
            bit_cnt   <= BW'(respLength - 2);
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == WW'(timeoutCycles - 1)) begin
              timeout <= 1'b1;
              finish  <= 1'b1;
            end
          end
        end
        RECEIVE: if (!fall) begin
          resp_data <= {resp_data[respLength-2:0], cmd_in};
          bit_cnt   <= bit_cnt - 1'b1;
          if (bit_cnt == '0) begin
            crc_ok  <= skip_q | (crc == resp_data[crcLength-1:0]);
            end_err <= ~cmd_in;
            finish  <= 1'b1;
          end
        end
        default: if (fall) finish <= 1'b0;
      endcase
    end
endmodule

// File: tb/tb_sd_resp_receiver.sv
// tb_sd_resp_receiver: directed frames against a polynomial-division reference model
module tb_sd_resp_receiver;
  import sd_pkg::*;
  logic clk = 0, rst_n = 0, use_module = 0, cmd_in = 1, skip_crc = 0;
  logic [7:0] generator = CRC7_POLY;
  logic [47:0] resp_data;
  logic busy, finish, crc_ok, end_err, timeout;
  int checks = 0, errors = 0;
  logic e_busy = 0, e_finish = 0, e_crc_ok = 0, e_end_err = 0, e_timeout = 0, e_resp_vld = 1;
  logic [47:0] e_resp = '0;
  always #5 clk = ~clk;
  sd_resp_receiver dut (
    .clk(clk), .rst_n(rst_n), .useModule(use_module), .cmd_in(cmd_in), .generator(generator),
    .skip_crc(skip_crc), .resp_data(resp_data), .busy(busy), .finish(finish),
    .crc_ok(crc_ok), .end_err(end_err), .timeout(timeout)
  );
  // remainder of body(x)*x^7 divided by the CRC7 polynomial, by long division
  function automatic logic [6:0] crc7_of(input logic [39:0] body);
    logic [46:0] r;
    r = {body, 7'b0};
    for (int i = 46; i >= 7; i--) if (r[i]) r[i -: 8] = r[i -: 8] ^ CRC7_POLY;
    return r[6:0];
  endfunction
  task automatic chk(input string name, input logic [47:0] got, input logic [47:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("busy", 48'(busy), 48'(e_busy));
    chk("finish", 48'(finish), 48'(e_finish));
    chk("crc_ok", 48'(crc_ok), 48'(e_crc_ok));
    chk("end_err", 48'(end_err), 48'(e_end_err));
    chk("timeout", 48'(timeout), 48'(e_timeout));
    if (e_resp_vld) chk("resp_data", resp_data, e_resp);
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic arm(input logic skip);
    use_module = 1;
    skip_crc = skip;
    cmd_in = 1;
    step();
    skip_crc = 0;
    {e_busy, e_finish, e_crc_ok, e_end_err, e_timeout, e_resp_vld} = 6'b100000;
  endtask
  task automatic run_frame(input logic [47:0] f, input logic skip, input int idle);
    arm(skip);
    repeat (idle) step();
    for (int b = 47; b >= 0; b--) begin
      cmd_in = f[b];
      step();
    end
    cmd_in = 1;
    e_busy = 0;
    e_finish = 1;
    e_crc_ok = skip | (crc7_of(f[47:8]) == f[7:1]);
    e_end_err = ~f[0];
    e_resp = f;
    e_resp_vld = 1;
    repeat (3) step();
    use_module = 0;
    step();
    e_finish = 0;
    step();
  endtask
  task automatic partial_frame(input logic [47:0] f);
    arm(1'b0);
    repeat (2) step();
    for (int b = 47; b > 27; b--) begin
      cmd_in = f[b];
      step();
    end
    #1;
  endtask
  initial begin
    chk("model_cmd0", 48'(crc7_of(40'h4000000000)), 48'h4A);
    chk("model_cmd8", 48'(crc7_of(40'h48000001AA)), 48'h43);
    chk("model_cmd17", 48'(crc7_of(40'h5100000000)), 48'h2A);
    repeat (2) step();
    rst_n = 1;
    step();
    run_frame(48'h400000000095, 1'b0, 3);
    run_frame(48'h48000001AA87, 1'b0, 1);
    run_frame(48'h510000000055, 1'b0, 0);
    run_frame(48'h48000001AB87, 1'b0, 2);
    run_frame(48'h48000001AB87, 1'b1, 2);
    run_frame(48'h400000000094, 1'b0, 5);
    arm(1'b0);
    repeat (63) step();
    step();
    {e_busy, e_finish, e_timeout} = 3'b011;
    repeat (2) step();
    use_module = 0;
    step();
    e_finish = 0;
    step();
    run_frame(48'h400000000095, 1'b0, 1);
    partial_frame(48'h48000001AA87);
    rst_n = 0;
    use_module = 0;
    cmd_in = 1;
    {e_busy, e_finish, e_crc_ok, e_end_err, e_timeout, e_resp_vld} = 6'b000001;
    e_resp = '0;
    repeat (2) step();
    rst_n = 1;
    step();
    partial_frame(48'h510000000055);
    use_module = 0;
    cmd_in = 1;
    step();
    e_busy = 0;
    repeat (50) step();
    run_frame(48'h48000001AA87, 1'b0, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
